// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: load/store unit between the memory stage and the data-memory port.
// Accepts one request per cycle, checks alignment, and issues word-aligned,
// byte-enabled requests through a single output register. Loads are tracked
// in an in-order FIFO; responses are aligned, extended and written back.
// Optional macro LSU_RSP_BYPASS_EN: when defined, the writeback outputs are
// driven combinationally in the response cycle instead of one cycle later.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and payload stable until that edge; ready may
// depend combinationally on the consumer's state but never on valid.
module lsu_dmem_if #(
    parameter int N_BITS          = 32,
    parameter int RF_IDX_WIDTH    = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic                    req_mtype,
    input  logic [1:0]              req_len,
    input  logic                    req_unsigned,
    input  logic [N_BITS-1:0]       req_addr,
    input  logic [N_BITS-1:0]       req_wdata,
    input  logic [RF_IDX_WIDTH-1:0] req_rd,
    output logic                    dmem_req_vld,
    input  logic                    dmem_req_rdy,
    output logic                    dmem_req_we,
    output logic [N_BITS-1:0]       dmem_req_addr,
    output logic [N_BITS/8-1:0]     dmem_req_be,
    output logic [N_BITS-1:0]       dmem_req_wdata,
    input  logic                    dmem_rsp_vld,
    input  logic [N_BITS-1:0]       dmem_rsp_rdata,
    output logic                    rf_wr_en,
    output logic [RF_IDX_WIDTH-1:0] rf_rd,
    output logic [N_BITS-1:0]       rf_wdata,
    output logic                    misalign_err,
    output logic                    busy
);

    localparam int BE_W  = N_BITS / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [RF_IDX_WIDTH-1:0] rd;
        logic [OFF_W-1:0]        off;
        logic [1:0]              len;
        logic                    uns;
    } trk_entry_t;

    trk_entry_t       trk_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] trk_cnt;

    logic [OFF_W-1:0]  req_off;
    logic              misaligned;
    logic [BE_W-1:0]   be_next;
    logic [N_BITS-1:0] wdata_next;
    logic              accept;
    logic              push;
    logic              pop;
    trk_entry_t        head;
    logic [N_BITS-1:0] shifted;
    logic [N_BITS-1:0] size_mask;
    logic              sign_bit;
    logic [N_BITS-1:0] wb_data;

    assign req_off = req_addr[OFF_W-1:0];
    assign req_rdy = (!dmem_req_vld || dmem_req_rdy) &&
                     (trk_cnt != CNT_W'(MAX_OUTSTANDING));
    assign accept  = req_vld && req_rdy;
    assign push    = accept && !misaligned && !req_mtype;
    assign pop     = dmem_rsp_vld && (trk_cnt != '0);
    assign busy    = dmem_req_vld || (trk_cnt != '0);
    assign head    = trk_mem[rd_ptr];

    // Alignment check: the access must sit on its natural boundary and fit the bus.
    always_comb begin
        misaligned = 1'b0;
        case (req_len)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = (N_BITS == 32) || (req_addr[2:0] != 3'b000);
        endcase
    end

    // Byte enables and lane-replicated store data for the accepted request.
    always_comb begin
        be_next    = '0;
        wdata_next = req_wdata;
        case (req_len)
            2'b00: begin
                be_next    = BE_W'(1) << req_off;
                wdata_next = {BE_W{req_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = BE_W'(2'b11) << req_off;
                wdata_next = {(N_BITS/16){req_wdata[15:0]}};
            end
            2'b10: begin
                be_next    = BE_W'(4'hF) << req_off;
                wdata_next = {(N_BITS/32){req_wdata[31:0]}};
            end
            default: begin
                be_next    = '1;
                wdata_next = req_wdata;
            end
        endcase
    end

    // Output register: load on an aligned acceptance, drop once the memory takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_vld   <= 1'b0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_be    <= '0;
            dmem_req_wdata <= '0;
        end else if (accept && !misaligned) begin
            dmem_req_vld   <= 1'b1;
            dmem_req_we    <= req_mtype;
            dmem_req_addr  <= {req_addr[N_BITS-1:OFF_W], {OFF_W{1'b0}}};
            dmem_req_be    <= be_next;
            dmem_req_wdata <= wdata_next;
        end else if (dmem_req_rdy) begin
            dmem_req_vld   <= 1'b0;
        end
    end

    // Misalignment pulse, one cycle after the offending request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= accept && misaligned;
    end

    // In-order load tracker: push on aligned load acceptance, pop on each response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            trk_cnt <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) trk_mem[i] <= '0;
        end else begin
            if (push) begin
                trk_mem[wr_ptr] <= '{rd: req_rd, off: req_off, len: req_len, uns: req_unsigned};
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop)      trk_cnt <= trk_cnt + 1'b1;
            else if (!push && pop) trk_cnt <= trk_cnt - 1'b1;
        end
    end

    // Load data: shift the addressed bytes down, trim to size, then extend.
    always_comb begin
        shifted   = dmem_rsp_rdata >> {head.off, 3'b000};
        size_mask = '0;
        sign_bit  = 1'b0;
        case (head.len)
            2'b00:   begin size_mask[7:0]  = '1; sign_bit = shifted[7];        end
            2'b01:   begin size_mask[15:0] = '1; sign_bit = shifted[15];       end
            2'b10:   begin size_mask[31:0] = '1; sign_bit = shifted[31];       end
            default: begin size_mask       = '1; sign_bit = shifted[N_BITS-1]; end
        endcase
        wb_data = shifted & size_mask;
        if (!head.uns && sign_bit) wb_data = wb_data | ~size_mask;
    end

`ifdef LSU_RSP_BYPASS_EN
    // Zero-latency writeback straight from the response and the tracker head.
    assign rf_wr_en = pop && (head.rd != '0);
    assign rf_rd    = head.rd;
    assign rf_wdata = wb_data;
`else
    // Registered writeback; x0 destinations still pop but never write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wr_en <= pop && (head.rd != '0);
            if (pop) begin
                rf_rd    <= head.rd;
                rf_wdata <= wb_data;
            end
        end
    end
`endif

endmodule
